// File: rtl/uart_pkg.sv
// Shared types and constants for the UART RX register bank.
// The optional 8E1 framing is selected by the UART_RX_PARITY_EN macro.
package uart_pkg;

    localparam int ADDR_W     = 7;
    localparam int BURST_FLAG = 7;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic [1:0] {
        P_ADDR,
        P_COUNT,
        P_DATA
    } proto_state_t;

    function automatic int baud_div(input int clk_freq, input int baud_rate, input int oversample);
        return clk_freq / (baud_rate * oversample);
    endfunction

    // Every byte is charged 10 bit-times, with or without a parity bit.
    function automatic int timeout_ticks(input int chars, input int oversample);
        return chars * 10 * oversample;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Baud generator, rx synchroniser and oversampling receive FSM.
// Defining UART_RX_PARITY_EN adds an even-parity bit between data and stop.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       baud_tick,
    output logic       byte_valid,
    output logic [7:0] data_byte,
    output logic       frame_err_pulse
);
    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int DIV_W    = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);
    localparam int OS_W     = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] MID_TICK  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] LAST_TICK = OS_W'(OVERSAMPLE - 1);

    if (BAUD_DIV < 2) begin : g_div_check
        $error("uart_rx_core: BAUD_DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be >= 2");
    end
    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_os_check
        $error("uart_rx_core: OVERSAMPLE must be even and >= 4");
    end

    logic [DIV_W-1:0] div_cnt_reg;
    logic             rx_meta_reg, rx_sync_reg;
    rx_state_t        state_reg, state_next;
    logic [OS_W-1:0]  tick_cnt_reg, tick_cnt_next;
    logic [2:0]       bit_cnt_reg, bit_cnt_next;
    logic [7:0]       shift_reg, shift_next;
    logic             parity_bad_reg, parity_bad_next;
    logic             byte_valid_reg, byte_valid_next;
    logic             frame_err_reg, frame_err_next;
    logic             sample_point;

    assign baud_tick       = (div_cnt_reg == DIV_W'(BAUD_DIV - 1));
    assign sample_point    = (tick_cnt_reg == LAST_TICK);
    assign byte_valid      = byte_valid_reg;
    assign data_byte       = shift_reg;
    assign frame_err_pulse = frame_err_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_reg    <= '0;
            rx_meta_reg    <= 1'b1;
            rx_sync_reg    <= 1'b1;
            state_reg      <= RX_IDLE;
            tick_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            parity_bad_reg <= 1'b0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            div_cnt_reg    <= baud_tick ? '0 : div_cnt_reg + 1'b1;
            rx_meta_reg    <= rx;
            rx_sync_reg    <= rx_meta_reg;
            state_reg      <= state_next;
            tick_cnt_reg   <= tick_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            parity_bad_reg <= parity_bad_next;
            byte_valid_reg <= byte_valid_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        tick_cnt_next   = tick_cnt_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        parity_bad_next = parity_bad_reg;
        byte_valid_next = 1'b0;
        frame_err_next  = 1'b0;
        if (baud_tick) begin
            case (state_reg)
                RX_IDLE: begin
                    if (!rx_sync_reg) begin
                        state_next    = RX_START;
                        tick_cnt_next = '0;
                    end
                end
                RX_START: begin
                    // Re-check at mid start bit so short low glitches are rejected.
                    if (tick_cnt_reg == MID_TICK) begin
                        tick_cnt_next   = '0;
                        bit_cnt_next    = '0;
                        parity_bad_next = 1'b0;
                        state_next      = rx_sync_reg ? RX_IDLE : RX_DATA;
                    end else begin
                        tick_cnt_next = tick_cnt_reg + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (sample_point) begin
                        tick_cnt_next = '0;
                        shift_next    = {rx_sync_reg, shift_reg[7:1]};
                        bit_cnt_next  = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_next = RX_PARITY;
`else
                            state_next = RX_STOP;
`endif
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    if (sample_point) begin
                        tick_cnt_next = '0;
                        state_next    = RX_STOP;
                        if (rx_sync_reg != ^shift_reg) begin
                            parity_bad_next = 1'b1;
                            frame_err_next  = 1'b1;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + 1'b1;
                    end
                end
`endif
                RX_STOP: begin
                    if (sample_point) begin
                        tick_cnt_next = '0;
                        if (rx_sync_reg) begin
                            byte_valid_next = !parity_bad_reg;
                            state_next      = RX_IDLE;
                        end else begin
                            frame_err_next = 1'b1;
                            state_next     = RX_WAIT_HIGH;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_sync_reg) state_next = RX_IDLE;
                end
                default: state_next = RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_regfile.sv
// UART-controlled register bank: single and auto-incrementing burst writes.
// UART_RX_PARITY_EN (passed through to uart_rx_core) selects 8E1 framing.
module uart_rx_regfile
    import uart_pkg::*;
#(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int BAUD_RATE     = 115200,
    parameter int OVERSAMPLE    = 8,
    parameter int NUM_REGS      = 8,
    parameter logic [NUM_REGS*8-1:0] RESET_VALS = {NUM_REGS{8'h00}},
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx,
    input  logic                    err_clr,
    output logic [NUM_REGS*8-1:0]   regs_flat,
    output logic                    wr_strobe,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [7:0]              wr_data,
    output logic                    frame_err,
    output logic                    proto_timeout
);
    localparam int TO_TICKS = timeout_ticks(TIMEOUT_CHARS, OVERSAMPLE);
    localparam int TO_W     = $clog2(TO_TICKS + 1);

    if (NUM_REGS < 1 || NUM_REGS > 128) begin : g_regs_check
        $error("uart_rx_regfile: NUM_REGS must be in 1..128");
    end

    logic        baud_tick, byte_valid, frame_err_pulse;
    logic [7:0]  data_byte;

    proto_state_t      pstate_reg, pstate_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [7:0]        remaining_reg, remaining_next;
    logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
    logic              wr_en, addr_in_range, proto_timeout_next;
    logic              wr_strobe_reg, frame_err_reg, proto_timeout_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [7:0]        wr_data_reg;

    uart_rx_core #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_core (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx              (rx),
        .baud_tick       (baud_tick),
        .byte_valid      (byte_valid),
        .data_byte       (data_byte),
        .frame_err_pulse (frame_err_pulse)
    );

    assign addr_in_range = ({1'b0, addr_reg} < 8'(NUM_REGS));

    always_comb begin
        pstate_next        = pstate_reg;
        addr_next          = addr_reg;
        remaining_next     = remaining_reg;
        to_cnt_next        = to_cnt_reg;
        wr_en              = 1'b0;
        proto_timeout_next = 1'b0;
        if (frame_err_pulse) begin
            pstate_next = P_ADDR;
            to_cnt_next = '0;
        end else if (byte_valid) begin
            to_cnt_next = '0;
            case (pstate_reg)
                P_ADDR: begin
                    addr_next = data_byte[ADDR_W-1:0];
                    if (data_byte[BURST_FLAG]) begin
                        pstate_next = P_COUNT;
                    end else begin
                        remaining_next = 8'd1;
                        pstate_next    = P_DATA;
                    end
                end
                P_COUNT: begin
                    remaining_next = data_byte;
                    pstate_next    = (data_byte == 8'd0) ? P_ADDR : P_DATA;
                end
                P_DATA: begin
                    // Out-of-range addresses still consume a byte and advance.
                    wr_en          = addr_in_range;
                    addr_next      = addr_reg + 1'b1;
                    remaining_next = remaining_reg - 8'd1;
                    if (remaining_reg == 8'd1) pstate_next = P_ADDR;
                end
                default: pstate_next = P_ADDR;
            endcase
        end else if (pstate_reg == P_ADDR) begin
            to_cnt_next = '0;
        end else if (baud_tick) begin
            if (to_cnt_reg == TO_W'(TO_TICKS - 1)) begin
                to_cnt_next        = '0;
                pstate_next        = P_ADDR;
                proto_timeout_next = 1'b1;
            end else begin
                to_cnt_next = to_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pstate_reg        <= P_ADDR;
            addr_reg          <= '0;
            remaining_reg     <= '0;
            to_cnt_reg        <= '0;
            wr_strobe_reg     <= 1'b0;
            wr_addr_reg       <= '0;
            wr_data_reg       <= '0;
            frame_err_reg     <= 1'b0;
            proto_timeout_reg <= 1'b0;
        end else begin
            pstate_reg        <= pstate_next;
            addr_reg          <= addr_next;
            remaining_reg     <= remaining_next;
            to_cnt_reg        <= to_cnt_next;
            wr_strobe_reg     <= wr_en;
            proto_timeout_reg <= proto_timeout_next;
            if (wr_en) begin
                wr_addr_reg <= addr_reg;
                wr_data_reg <= data_byte;
            end
            // A new error on the same edge as err_clr keeps the flag set.
            if (frame_err_pulse)  frame_err_reg <= 1'b1;
            else if (err_clr)     frame_err_reg <= 1'b0;
        end
    end

    genvar gi;
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
        logic [7:0] value_reg;
        always_ff @(posedge clk) begin
            if (!rst_n)                                     value_reg <= RESET_VALS[8*gi +: 8];
            else if (wr_en && addr_reg == ADDR_W'(gi))      value_reg <= data_byte;
        end
        assign regs_flat[8*gi +: 8] = value_reg;
    end

    assign wr_strobe     = wr_strobe_reg;
    assign wr_addr       = wr_addr_reg;
    assign wr_data       = wr_data_reg;
    assign frame_err     = frame_err_reg;
    assign proto_timeout = proto_timeout_reg;

endmodule

// File: tb/tb_uart_rx_regfile.sv
// Directed bench for uart_rx_regfile: 16 clocks per bit (BAUD_DIV=2, OVERSAMPLE=8).
// With UART_RX_PARITY_EN defined every frame carries an even-parity bit.
module tb_uart_rx_regfile;
    localparam int          BIT_CLKS = 16;
    localparam logic [63:0] RST_IMG  = 64'hF7E6D5C4B3A29180;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        err_clr = 1'b0;
    logic [63:0] regs_flat;
    logic        wr_strobe;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        frame_err;
    logic        proto_timeout;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int timeout_cnt = 0;
    int s0, t0;

    uart_rx_regfile #(
        .CLK_FREQ      (1_600_000),
        .BAUD_RATE     (100_000),
        .OVERSAMPLE    (8),
        .NUM_REGS      (8),
        .RESET_VALS    (RST_IMG),
        .TIMEOUT_CHARS (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx),
        .err_clr       (err_clr),
        .regs_flat     (regs_flat),
        .wr_strobe     (wr_strobe),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .frame_err     (frame_err),
        .proto_timeout (proto_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe)     strobe_cnt++;
        if (proto_timeout) timeout_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // A low stop bit leaves the line low so the caller controls the break.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic wrong_parity);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ wrong_parity);
`else
        if (wrong_parity) $display("note: parity not configured, flag ignored");
`endif
        send_bit(stop_bit);
        if (stop_bit) begin
            rx = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_frame(d, 1'b1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(negedge clk);
        check("reset_regs", regs_flat, RST_IMG);
        check("reset_strobe", wr_strobe, 0);
        check("reset_wr_addr", wr_addr, 0);
        check("reset_wr_data", wr_data, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_timeout", proto_timeout, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Single write
        s0 = strobe_cnt;
        send_byte(8'h03);
        send_byte(8'hA5);
        check("single_strobes", strobe_cnt - s0, 1);
        check("single_wr_addr", wr_addr, 3);
        check("single_wr_data", wr_data, 8'hA5);
        check("single_regs", regs_flat, 64'hF7E6D5C4A5A29180);

        // Burst of 3 from address 6: third byte lands on address 8 and is dropped
        s0 = strobe_cnt;
        send_byte(8'h86);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        check("burst_strobes", strobe_cnt - s0, 2);
        check("burst_wr_addr", wr_addr, 7);
        check("burst_wr_data", wr_data, 8'h22);
        check("burst_regs", regs_flat, 64'h2211D5C4A5A29180);
        send_byte(8'h00);
        send_byte(8'h5C);
        check("post_burst_addr", wr_addr, 0);
        check("post_burst_regs", regs_flat, 64'h2211D5C4A5A2915C);

        // Frame error followed by a 3 bit-time break
        send_frame(8'h02, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (3 * BIT_CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("frame_err_set", frame_err, 1);
        send_byte(8'h01);
        send_byte(8'h5A);
        check("frame_err_regs", regs_flat, 64'h2211D5C4A5A25A5C);
        check("frame_err_sticky", frame_err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        check("frame_err_cleared", frame_err, 0);

        // Inter-byte timeout resync
        t0 = timeout_cnt;
        send_byte(8'h04);
        for (int i = 0; i < 1000 && timeout_cnt == t0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("timeout_pulses", timeout_cnt - t0, 1);
        send_byte(8'h05);
        send_byte(8'h77);
        check("timeout_regs", regs_flat, 64'h221177C4A5A25A5C);

        // Glitch shorter than half a bit
        s0 = strobe_cnt;
        rx = 1'b0;
        repeat (BIT_CLKS / 2 - 2) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT_CLKS) @(negedge clk);
        check("glitch_strobes", strobe_cnt - s0, 0);
        check("glitch_frame_err", frame_err, 0);
        send_byte(8'h07);
        send_byte(8'h3C);
        check("post_glitch_strobes", strobe_cnt - s0, 1);
        check("post_glitch_regs", regs_flat, 64'h3C1177C4A5A25A5C);

        // Reset in the middle of a data byte with an address pending
        send_byte(8'h01);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        check("midreset_regs", regs_flat, RST_IMG);
        check("midreset_wr_addr", wr_addr, 0);
        check("midreset_wr_data", wr_data, 0);
        rst_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        send_byte(8'h05);
        send_byte(8'h42);
        check("post_reset_regs", regs_flat, 64'hF7E642C4B3A29180);
        check("post_reset_wr_addr", wr_addr, 5);
        check("post_reset_wr_data", wr_data, 8'h42);

`ifdef UART_RX_PARITY_EN
        // Wrong parity on the data byte
        s0 = strobe_cnt;
        send_byte(8'h00);
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (BIT_CLKS) @(negedge clk);
        check("parity_frame_err", frame_err, 1);
        check("parity_strobes", strobe_cnt - s0, 0);
        check("parity_regs", regs_flat, 64'hF7E642C4B3A29180);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
